decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Instruction decode stage of the 5-stage RV32I pipeline. It sits between the fetch IF/ID register and execute, and drives the read-address ports of register_file. It consumes the register_file read data, applies a write-back bypass, and decodes control and immediates. It detects load-use hazards and holds the ID/EX pipeline register.

Parameters:
XLEN, 32, datapath width
RESET_PC, 32'h0000_0000, reset value of ex_pc_o

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
instr_i  in  XLEN  instruction from IF/ID register
pc_i  in  XLEN  PC of instr_i
instr_valid_i  in  1  instr_i is a real instruction
flush_i  in  1  branch/jump redirect from execute; kill the instruction in decode
rs1_addr_o  out  5  to register_file rs1_addr_i, instr_i[19:15]
rs2_addr_o  out  5  to register_file rs2_addr_i, instr_i[24:20]
rs1_data_i  in  XLEN  from register_file rs1_o
rs2_data_i  in  XLEN  from register_file rs2_o
wb_addr_i  in  5  write-back destination (same net as register_file wr_addr_i)
wb_data_i  in  XLEN  write-back data
wb_enable_i  in  1  write-back enable
stall_o  out  1  hold PC and IF/ID register
ex_valid_o  out  1  ID/EX holds a valid instruction
ex_pc_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o  out  XLEN  ID/EX datapath fields
ex_rd_addr_o, ex_rs1_addr_o, ex_rs2_addr_o  out  5  ID/EX register indices
ex_alu_op_o  out  4  ALU operation code (package encoding)
ex_funct3_o  out  3  funct3, for branch and memory width
ex_alu_src_imm_o, ex_alu_src_pc_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o, ex_jump_o, ex_illegal_o  out  1  ID/EX control bits

Behaviour:
- Reset (async, reset_n=0): every ex_* output is 0, except ex_pc_o=RESET_PC. All outputs stay in this state until the first rising edge after reset_n rises.
- rs1_addr_o and rs2_addr_o are combinational from instr_i. They are driven even when no operand is used.
- Bypass: if wb_enable_i=1, wb_addr_i!=0 and wb_addr_i==rsN_addr_o, then the operand is wb_data_i; otherwise it is rsN_data_i.
- Operand used: rs1 is used by R, I-ALU, LOAD, STORE, BRANCH and JALR. rs2 is used by R, STORE and BRANCH.
- Load-use hazard: asserted when all of the following hold:
  - ex_valid_o=1, ex_mem_read_o=1 and ex_rd_addr_o!=0;
  - ex_rd_addr_o equals a used source of instr_i;
  - instr_valid_i=1.
- Hazard response: stall_o=1 (combinational). On the next edge ID/EX loads a bubble: ex_valid_o=0 and all control bits 0; datapath fields are don't-care. Stall lasts exactly 1 cycle per load.
- flush_i=1: next edge loads a bubble, and stall_o=0. Flush has priority over hazard.
- instr_valid_i=0: next edge loads a bubble.
- Otherwise, ID/EX captures the decoded instruction with 1-cycle latency.
- Immediates: I, S, B, U and J formats, sign-extended from instr_i[31]. B and J immediates have bit0=0. U immediate is {instr[31:12],12'b0}.
- Control per opcode:
  - OP: alu_op from funct3/funct7[5].
  - OP-IMM: alu_src_imm=1. funct7[5] selects SRA vs SRL only for shift-right; for ADDI it is ignored.
  - LOAD: mem_read=1, alu=ADD.
  - STORE: mem_write=1, reg_write=0, alu=ADD.
  - BRANCH: branch=1, reg_write=0, alu=SUB.
  - LUI: alu=PASS_B.
  - AUIPC: alu_src_pc=1, alu=ADD.
  - JAL/JALR: jump=1, reg_write=1.
- reg_write is forced to 0 whenever rd=0.
- Illegal (unknown opcode, or bad funct7 on OP): ex_illegal_o=1 with reg_write, mem_read, mem_write, branch and jump all 0. ex_valid_o=1.
- Simultaneous bypass and hazard: the hazard wins (stall). The bypass still applies on the replay cycle.

Decomposition:
- Package rv32_pkg holds:
  - opcode constants: OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR;
  - ALU codes: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10;
  - the immediate-format enum.
- One combinational sub-module, imm_gen (instr -> sign-extended imm). The hazard unit and the ID/EX register stay in decode_stage.

Test Plan:
- Reset: reset_n=0 mid-run with instr_i=0x00500093 -> all ex_* outputs 0 and ex_pc_o=RESET_PC, immediately and without a clock edge.
- addi x1,x0,5 (0x00500093) at pc=0x10 -> next cycle: ex_valid=1, ex_imm=5, ex_rd=1, reg_write=1, alu_src_imm=1, alu_op=ADD, ex_pc=0x10. addi x1,x0,-1 (0xFFF00093) -> ex_imm=0xFFFFFFFF.
- Bypass: instr 0x002081B3 (add x3,x1,x2) with register_file rs1_o=0 and wb_enable=1, wb_addr=1, wb_data=0xDEADBEEF -> ex_rs1_data=0xDEADBEEF. Same stimulus with wb_addr=0 -> ex_rs1_data=0.
- Load-use: lw x5,0(x1) (0x0000A283), then add x6,x5,x5 (0x00528333):
  - second cycle: stall_o=1; next edge: ex_valid=0;
  - the following cycle: stall_o=0, add captured with rs1=rs2=5.
  - sw x2,8(x1) (0x0020A423) after lw x5 -> no stall; ex_imm=8, mem_write=1, reg_write=0.
- Flush with hazard pending: lw x5 in EX, add x6,x5,x5 in decode, flush_i=1 -> stall_o=0, next ex_valid=0.
- Illegal: instr 0xFFFFFFFF -> ex_valid=1, ex_illegal=1, reg_write=0, mem_read=0, mem_write=0, branch=0, jump=0.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU encodings, immediate formats
// and the control bundle carried through the ID/EX register.
package rv32_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src_imm;
    logic    alu_src_pc;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    alu_op:      ALU_ADD,
    alu_src_imm: 1'b0,
    alu_src_pc:  1'b0,
    reg_write:   1'b0,
    mem_read:    1'b0,
    mem_write:   1'b0,
    branch:      1'b0,
    jump:        1'b0,
    illegal:     1'b0
  };

  // funct3 selects the operation; alt (funct7[5]) picks SUB/SRA where meaningful
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic op_funct7_ok(input logic [2:0] funct3, input logic [6:0] funct7);
    return (funct7 == 7'b0000000) ||
           ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
  endfunction

  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = IMM_I;
      OPC_STORE:                      fmt = IMM_S;
      OPC_BRANCH:                     fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
      OPC_JAL:                        fmt = IMM_J;
      default:                        fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: picks the RV32I immediate format from the opcode and
// returns the value sign-extended from instr[31] to XLEN bits.
module imm_gen
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  imm_fmt_e fmt_s;

  assign fmt_s = imm_fmt_of(instr[6:0]);

  // Bit scrambling of each format; B and J are half-word offsets so bit 0 is zero
  always_comb begin
    imm = {XLEN{1'b0}};
    case (fmt_s)
      IMM_I:   imm = {{(XLEN-11){instr[31]}}, instr[30:20]};
      IMM_S:   imm = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
      IMM_B:   imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'h000};
      IMM_J:   imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_NONE: imm = {XLEN{1'b0}};
      default: imm = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register-file addressing, write-back bypass, control
// decode, load-use hazard detection and the ID/EX pipeline register.
module decode_stage
  import rv32_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            instr_valid_i,
  input  logic            flush_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            wb_enable_i,
  output logic            stall_o,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [XLEN-1:0] ex_rs1_data_o,
  output logic [XLEN-1:0] ex_rs2_data_o,
  output logic [4:0]      ex_rd_addr_o,
  output logic [4:0]      ex_rs1_addr_o,
  output logic [4:0]      ex_rs2_addr_o,
  output logic [3:0]      ex_alu_op_o,
  output logic [2:0]      ex_funct3_o,
  output logic            ex_alu_src_imm_o,
  output logic            ex_alu_src_pc_o,
  output logic            ex_reg_write_o,
  output logic            ex_mem_read_o,
  output logic            ex_mem_write_o,
  output logic            ex_branch_o,
  output logic            ex_jump_o,
  output logic            ex_illegal_o
);

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [6:0]      funct7_s;
  logic [4:0]      rd_s;
  ctrl_t           ctrl_s;
  logic            use_rs1_s;
  logic            use_rs2_s;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] rs1_fwd_s;
  logic [XLEN-1:0] rs2_fwd_s;
  logic            load_pending_s;
  logic            hazard_s;
  logic            bubble_s;

  logic            ex_valid_r;
  logic [XLEN-1:0] ex_pc_r;
  logic [XLEN-1:0] ex_imm_r;
  logic [XLEN-1:0] ex_rs1_data_r;
  logic [XLEN-1:0] ex_rs2_data_r;
  logic [4:0]      ex_rd_r;
  logic [4:0]      ex_rs1_addr_r;
  logic [4:0]      ex_rs2_addr_r;
  logic [2:0]      ex_funct3_r;
  ctrl_t           ex_ctrl_r;

  assign opcode_s   = instr_i[6:0];
  assign rd_s       = instr_i[11:7];
  assign funct3_s   = instr_i[14:12];
  assign funct7_s   = instr_i[31:25];
  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (instr_i[31:0]),
    .imm   (imm_s)
  );

  // Control decode and which source registers the instruction actually reads
  always_comb begin
    ctrl_s    = CTRL_NOP;
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        if (op_funct7_ok(funct3_s, funct7_s)) begin
          ctrl_s.alu_op    = alu_from_funct3(funct3_s, funct7_s[5]);
          ctrl_s.reg_write = 1'b1;
        end else begin
          ctrl_s.illegal   = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        use_rs1_s          = 1'b1;
        ctrl_s.alu_op      = alu_from_funct3(funct3_s, funct7_s[5] & (funct3_s == 3'b101));
        ctrl_s.alu_src_imm = 1'b1;
        ctrl_s.reg_write   = 1'b1;
      end
      OPC_LOAD: begin
        use_rs1_s          = 1'b1;
        ctrl_s.alu_src_imm = 1'b1;
        ctrl_s.mem_read    = 1'b1;
        ctrl_s.reg_write   = 1'b1;
      end
      OPC_STORE: begin
        use_rs1_s          = 1'b1;
        use_rs2_s          = 1'b1;
        ctrl_s.alu_src_imm = 1'b1;
        ctrl_s.mem_write   = 1'b1;
      end
      OPC_BRANCH: begin
        use_rs1_s     = 1'b1;
        use_rs2_s     = 1'b1;
        ctrl_s.alu_op = ALU_SUB;
        ctrl_s.branch = 1'b1;
      end
      OPC_LUI: begin
        ctrl_s.alu_op      = ALU_PASS_B;
        ctrl_s.alu_src_imm = 1'b1;
        ctrl_s.reg_write   = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl_s.alu_src_imm = 1'b1;
        ctrl_s.alu_src_pc  = 1'b1;
        ctrl_s.reg_write   = 1'b1;
      end
      OPC_JAL: begin
        ctrl_s.jump      = 1'b1;
        ctrl_s.reg_write = 1'b1;
      end
      OPC_JALR: begin
        use_rs1_s          = 1'b1;
        ctrl_s.alu_src_imm = 1'b1;
        ctrl_s.jump        = 1'b1;
        ctrl_s.reg_write   = 1'b1;
      end
      default: begin
        ctrl_s.illegal = 1'b1;
      end
    endcase
    // x0 is never written, so suppress the write-back request up front
    ctrl_s.reg_write = ctrl_s.reg_write & (rd_s != 5'd0);
  end

  // The register file is read before the same-cycle write lands; forward it here
  assign rs1_fwd_s = (wb_enable_i && (wb_addr_i != 5'd0) && (wb_addr_i == rs1_addr_o)) ?
                     wb_data_i : rs1_data_i;
  assign rs2_fwd_s = (wb_enable_i && (wb_addr_i != 5'd0) && (wb_addr_i == rs2_addr_o)) ?
                     wb_data_i : rs2_data_i;

  assign load_pending_s = ex_valid_r & ex_ctrl_r.mem_read & (ex_rd_r != 5'd0);
  assign hazard_s       = load_pending_s & instr_valid_i &
                          ((use_rs1_s & (ex_rd_r == rs1_addr_o)) |
                           (use_rs2_s & (ex_rd_r == rs2_addr_o)));
  // A redirect discards the dependent instruction, so there is nothing to hold
  assign stall_o        = hazard_s & ~flush_i;
  assign bubble_s       = flush_i | ~instr_valid_i | hazard_s;

  // ID/EX register: bubbles clear valid and control, datapath fields are left as-is
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_r    <= 1'b0;
      ex_pc_r       <= RESET_PC;
      ex_imm_r      <= {XLEN{1'b0}};
      ex_rs1_data_r <= {XLEN{1'b0}};
      ex_rs2_data_r <= {XLEN{1'b0}};
      ex_rd_r       <= 5'd0;
      ex_rs1_addr_r <= 5'd0;
      ex_rs2_addr_r <= 5'd0;
      ex_funct3_r   <= 3'd0;
      ex_ctrl_r     <= CTRL_NOP;
    end else if (bubble_s) begin
      ex_valid_r    <= 1'b0;
      ex_ctrl_r     <= CTRL_NOP;
    end else begin
      ex_valid_r    <= 1'b1;
      ex_pc_r       <= pc_i;
      ex_imm_r      <= imm_s;
      ex_rs1_data_r <= rs1_fwd_s;
      ex_rs2_data_r <= rs2_fwd_s;
      ex_rd_r       <= rd_s;
      ex_rs1_addr_r <= rs1_addr_o;
      ex_rs2_addr_r <= rs2_addr_o;
      ex_funct3_r   <= funct3_s;
      ex_ctrl_r     <= ctrl_s;
    end
  end

  assign ex_valid_o       = ex_valid_r;
  assign ex_pc_o          = ex_pc_r;
  assign ex_imm_o         = ex_imm_r;
  assign ex_rs1_data_o    = ex_rs1_data_r;
  assign ex_rs2_data_o    = ex_rs2_data_r;
  assign ex_rd_addr_o     = ex_rd_r;
  assign ex_rs1_addr_o    = ex_rs1_addr_r;
  assign ex_rs2_addr_o    = ex_rs2_addr_r;
  assign ex_alu_op_o      = ex_ctrl_r.alu_op;
  assign ex_funct3_o      = ex_funct3_r;
  assign ex_alu_src_imm_o = ex_ctrl_r.alu_src_imm;
  assign ex_alu_src_pc_o  = ex_ctrl_r.alu_src_pc;
  assign ex_reg_write_o   = ex_ctrl_r.reg_write;
  assign ex_mem_read_o    = ex_ctrl_r.mem_read;
  assign ex_mem_write_o   = ex_ctrl_r.mem_write;
  assign ex_branch_o      = ex_ctrl_r.branch;
  assign ex_jump_o        = ex_ctrl_r.jump;
  assign ex_illegal_o     = ex_ctrl_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected ID/EX contents are queued when a
// step is driven and compared one clock later when the register updates.
module tb_decode_stage;

  localparam logic [3:0] A_ADD  = 4'd0;
  localparam logic [3:0] A_SUB  = 4'd1;
  localparam logic [3:0] A_PASS = 4'd10;

  typedef struct {
    logic        valid;
    logic        chk_dp;
    logic        chk_imm;
    logic [31:0] pc, imm, rs1d, rs2d;
    logic [4:0]  rd, a1, a2;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        src_imm, src_pc, rw, mr, mw, br, jp, ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i, wb_data_i;
  logic        instr_valid_i, flush_i, wb_enable_i;
  logic [4:0]  wb_addr_i;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic        stall_o, ex_valid_o;
  logic [31:0] ex_pc_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o;
  logic [4:0]  ex_rd_addr_o, ex_rs1_addr_o, ex_rs2_addr_o;
  logic [3:0]  ex_alu_op_o;
  logic [2:0]  ex_funct3_o;
  logic        ex_alu_src_imm_o, ex_alu_src_pc_o, ex_reg_write_o, ex_mem_read_o;
  logic        ex_mem_write_o, ex_branch_o, ex_jump_o, ex_illegal_o;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  exp_t e;

  decode_stage dut (
    .clk(clk), .reset_n(reset_n), .instr_i(instr_i), .pc_i(pc_i),
    .instr_valid_i(instr_valid_i), .flush_i(flush_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_enable_i(wb_enable_i),
    .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
    .ex_imm_o(ex_imm_o), .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_rd_addr_o(ex_rd_addr_o), .ex_rs1_addr_o(ex_rs1_addr_o), .ex_rs2_addr_o(ex_rs2_addr_o),
    .ex_alu_op_o(ex_alu_op_o), .ex_funct3_o(ex_funct3_o),
    .ex_alu_src_imm_o(ex_alu_src_imm_o), .ex_alu_src_pc_o(ex_alu_src_pc_o),
    .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o),
    .ex_mem_write_o(ex_mem_write_o), .ex_branch_o(ex_branch_o),
    .ex_jump_o(ex_jump_o), .ex_illegal_o(ex_illegal_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, imm, r1d, r2d,
                              input logic [4:0] rd, a1, a2,
                              input logic [2:0] f3, input logic [3:0] alu);
    exp_t x;
    x.valid = 1'b1; x.chk_dp = 1'b1; x.chk_imm = 1'b1;
    x.pc = pc; x.imm = imm; x.rs1d = r1d; x.rs2d = r2d;
    x.rd = rd; x.a1 = a1; x.a2 = a2; x.f3 = f3; x.alu = alu;
    x.src_imm = 1'b0; x.src_pc = 1'b0; x.rw = 1'b0; x.mr = 1'b0;
    x.mw = 1'b0; x.br = 1'b0; x.jp = 1'b0; x.ill = 1'b0;
    return x;
  endfunction

  function automatic exp_t bubble();
    exp_t x;
    x = mk(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 3'd0, 4'd0);
    x.valid = 1'b0; x.chk_dp = 1'b0; x.chk_imm = 1'b0;
    return x;
  endfunction

  task automatic drive(input logic [31:0] ins, pc, input logic v, fl,
                       input logic [31:0] d1, d2, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    instr_i = ins; pc_i = pc; instr_valid_i = v; flush_i = fl;
    rs1_data_i = d1; rs2_data_i = d2; wb_enable_i = we; wb_addr_i = wa; wb_data_i = wd;
  endtask

  task automatic compare(input exp_t x);
    chk("ex_valid", 32'(ex_valid_o), 32'(x.valid));
    chk("ex_illegal", 32'(ex_illegal_o), 32'(x.ill));
    chk("ex_reg_write", 32'(ex_reg_write_o), 32'(x.rw));
    chk("ex_mem_read", 32'(ex_mem_read_o), 32'(x.mr));
    chk("ex_mem_write", 32'(ex_mem_write_o), 32'(x.mw));
    chk("ex_branch", 32'(ex_branch_o), 32'(x.br));
    chk("ex_jump", 32'(ex_jump_o), 32'(x.jp));
    chk("ex_alu_src_imm", 32'(ex_alu_src_imm_o), 32'(x.src_imm));
    chk("ex_alu_src_pc", 32'(ex_alu_src_pc_o), 32'(x.src_pc));
    if (x.chk_dp) begin
      chk("ex_pc", ex_pc_o, x.pc);
      chk("ex_rs1_data", ex_rs1_data_o, x.rs1d);
      chk("ex_rs2_data", ex_rs2_data_o, x.rs2d);
      chk("ex_rd_addr", 32'(ex_rd_addr_o), 32'(x.rd));
      chk("ex_rs1_addr", 32'(ex_rs1_addr_o), 32'(x.a1));
      chk("ex_rs2_addr", 32'(ex_rs2_addr_o), 32'(x.a2));
      chk("ex_funct3", 32'(ex_funct3_o), 32'(x.f3));
      chk("ex_alu_op", 32'(ex_alu_op_o), 32'(x.alu));
    end
    if (x.chk_imm) chk("ex_imm", ex_imm_o, x.imm);
  endtask

  // Called at a falling edge after drive(): checks stall, then the next ID/EX value
  task automatic step(input exp_t x, input logic exp_stall);
    sb_q.push_back(x);
    #1;
    chk("stall", 32'(stall_o), 32'(exp_stall));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++; n_errors++;
      $error("FAIL scoreboard: observed empty queue expected one entry");
    end else begin
      compare(sb_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(ex_valid_o), 32'h0);
    chk({tag, "_pc"}, ex_pc_o, 32'h0000_0000);
    chk({tag, "_imm"}, ex_imm_o, 32'h0);
    chk({tag, "_rs1_data"}, ex_rs1_data_o, 32'h0);
    chk({tag, "_rs2_data"}, ex_rs2_data_o, 32'h0);
    chk({tag, "_rd"}, 32'(ex_rd_addr_o), 32'h0);
    chk({tag, "_rs_addr"}, 32'({ex_rs1_addr_o, ex_rs2_addr_o}), 32'h0);
    chk({tag, "_alu_f3"}, 32'({ex_alu_op_o, ex_funct3_o}), 32'h0);
    chk({tag, "_ctrl"}, 32'({ex_alu_src_imm_o, ex_alu_src_pc_o, ex_reg_write_o, ex_mem_read_o,
                             ex_mem_write_o, ex_branch_o, ex_jump_o, ex_illegal_o}), 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(negedge clk);
    chk_reset("reset");
    reset_n = 1'b1;

    // addi x1,x0,5 and addi x1,x0,-1
    drive(32'h00500093, 32'h10, 1'b1, 1'b0, 32'h0, 32'h777, 1'b0, 5'd0, 32'h0);
    chk("rs1_addr", 32'(rs1_addr_o), 32'd0);
    chk("rs2_addr", 32'(rs2_addr_o), 32'd5);
    e = mk(32'h10, 32'd5, 32'h0, 32'h777, 5'd1, 5'd0, 5'd5, 3'd0, A_ADD);
    e.src_imm = 1'b1; e.rw = 1'b1; step(e, 1'b0);
    drive(32'hFFF00093, 32'h14, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    e = mk(32'h14, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd1, 5'd0, 5'd31, 3'd0, A_ADD);
    e.src_imm = 1'b1; e.rw = 1'b1; step(e, 1'b0);

    // add x3,x1,x2 with write-back bypass variants
    drive(32'h002081B3, 32'h18, 1'b1, 1'b0, 32'h0, 32'h22, 1'b1, 5'd1, 32'hDEADBEEF);
    e = mk(32'h18, 32'h0, 32'hDEADBEEF, 32'h22, 5'd3, 5'd1, 5'd2, 3'd0, A_ADD);
    e.chk_imm = 1'b0; e.rw = 1'b1; step(e, 1'b0);
    drive(32'h002081B3, 32'h1C, 1'b1, 1'b0, 32'h0, 32'h22, 1'b1, 5'd0, 32'hDEADBEEF);
    e = mk(32'h1C, 32'h0, 32'h0, 32'h22, 5'd3, 5'd1, 5'd2, 3'd0, A_ADD);
    e.chk_imm = 1'b0; e.rw = 1'b1; step(e, 1'b0);
    drive(32'h002081B3, 32'h20, 1'b1, 1'b0, 32'h11, 32'h22, 1'b1, 5'd2, 32'hCAFEF00D);
    e = mk(32'h20, 32'h0, 32'h11, 32'hCAFEF00D, 5'd3, 5'd1, 5'd2, 3'd0, A_ADD);
    e.chk_imm = 1'b0; e.rw = 1'b1; step(e, 1'b0);
    drive(32'h002081B3, 32'h22, 1'b1, 1'b0, 32'h11, 32'h22, 1'b0, 5'd1, 32'hCAFEF00D);
    e = mk(32'h22, 32'h0, 32'h11, 32'h22, 5'd3, 5'd1, 5'd2, 3'd0, A_ADD);
    e.chk_imm = 1'b0; e.rw = 1'b1; step(e, 1'b0);

    // sub, bad funct7 on OP, addi to x0
    drive(32'h402081B3, 32'h24, 1'b1, 1'b0, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0);
    e = mk(32'h24, 32'h0, 32'h1, 32'h2, 5'd3, 5'd1, 5'd2, 3'd0, A_SUB);
    e.chk_imm = 1'b0; e.rw = 1'b1; step(e, 1'b0);
    drive(32'h202081B3, 32'h28, 1'b1, 1'b0, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0);
    e = bubble(); e.valid = 1'b1; e.ill = 1'b1; step(e, 1'b0);
    drive(32'h00100013, 32'h2C, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    e = mk(32'h2C, 32'd1, 32'h0, 32'h0, 5'd0, 5'd0, 5'd1, 3'd0, A_ADD);
    e.src_imm = 1'b1; step(e, 1'b0);

    // lw x5,0(x1) then add x6,x5,x5: one-cycle stall, bypass applies on replay
    drive(32'h0000A283, 32'h30, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 5'd0, 32'h0);
    e = mk(32'h30, 32'h0, 32'h100, 32'h0, 5'd5, 5'd1, 5'd0, 3'd2, A_ADD);
    e.src_imm = 1'b1; e.mr = 1'b1; e.rw = 1'b1; step(e, 1'b0);
    drive(32'h00528333, 32'h34, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h55);
    step(bubble(), 1'b1);
    e = mk(32'h34, 32'h0, 32'h55, 32'h55, 5'd6, 5'd5, 5'd5, 3'd0, A_ADD);
    e.chk_imm = 1'b0; e.rw = 1'b1; step(e, 1'b0);

    // lw x5 then sw x2,8(x1): independent, no stall
    drive(32'h0000A283, 32'h38, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 5'd0, 32'h0);
    e = mk(32'h38, 32'h0, 32'h100, 32'h0, 5'd5, 5'd1, 5'd0, 3'd2, A_ADD);
    e.src_imm = 1'b1; e.mr = 1'b1; e.rw = 1'b1; step(e, 1'b0);
    drive(32'h0020A423, 32'h3C, 1'b1, 1'b0, 32'h200, 32'h300, 1'b0, 5'd0, 32'h0);
    e = mk(32'h3C, 32'd8, 32'h200, 32'h300, 5'd8, 5'd1, 5'd2, 3'd2, A_ADD);
    e.src_imm = 1'b1; e.mw = 1'b1; step(e, 1'b0);

    // lw x5 then dependent add with flush: flush wins, no stall, bubble
    drive(32'h0000A283, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 5'd0, 32'h0);
    e = mk(32'h40, 32'h0, 32'h100, 32'h0, 5'd5, 5'd1, 5'd0, 3'd2, A_ADD);
    e.src_imm = 1'b1; e.mr = 1'b1; e.rw = 1'b1; step(e, 1'b0);
    drive(32'h00528333, 32'h44, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(bubble(), 1'b0);

    // beq x1,x2,+8 ; jal x1,-4 ; lui x1,0x12345
    drive(32'h00208463, 32'h48, 1'b1, 1'b0, 32'h1, 32'h1, 1'b0, 5'd0, 32'h0);
    e = mk(32'h48, 32'd8, 32'h1, 32'h1, 5'd8, 5'd1, 5'd2, 3'd0, A_SUB);
    e.br = 1'b1; step(e, 1'b0);
    drive(32'hFFDFF0EF, 32'h4C, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    e = mk(32'h4C, 32'hFFFFFFFC, 32'h0, 32'h0, 5'd1, 5'd31, 5'd29, 3'd7, A_ADD);
    e.jp = 1'b1; e.rw = 1'b1; step(e, 1'b0);
    drive(32'h123450B7, 32'h50, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    e = mk(32'h50, 32'h12345000, 32'h0, 32'h0, 5'd1, 5'd8, 5'd3, 3'd5, A_PASS);
    e.src_imm = 1'b1; e.rw = 1'b1; step(e, 1'b0);

    // all-ones opcode is illegal but still a valid ID/EX entry
    drive(32'hFFFFFFFF, 32'h54, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    e = bubble(); e.valid = 1'b1; e.ill = 1'b1; step(e, 1'b0);

    // instr_valid low gives a bubble, then a normal addi
    drive(32'h00500093, 32'h58, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(bubble(), 1'b0);
    drive(32'h00500093, 32'h5C, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    e = mk(32'h5C, 32'd5, 32'h0, 32'h0, 5'd1, 5'd0, 5'd5, 3'd0, A_ADD);
    e.src_imm = 1'b1; e.rw = 1'b1; step(e, 1'b0);

    // asynchronous reset mid-run, away from any clock edge
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("midreset");
    @(posedge clk);
    #1;
    chk("midreset_hold_valid", 32'(ex_valid_o), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // lw x5 then sw x5,8(x1): hazard through rs2 only
    drive(32'h0000A283, 32'h60, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 5'd0, 32'h0);
    e = mk(32'h60, 32'h0, 32'h100, 32'h0, 5'd5, 5'd1, 5'd0, 3'd2, A_ADD);
    e.src_imm = 1'b1; e.mr = 1'b1; e.rw = 1'b1; step(e, 1'b0);
    drive(32'h0050A423, 32'h64, 1'b1, 1'b0, 32'h400, 32'h500, 1'b0, 5'd0, 32'h0);
    step(bubble(), 1'b1);
    e = mk(32'h64, 32'd8, 32'h400, 32'h500, 5'd8, 5'd1, 5'd5, 3'd2, A_ADD);
    e.src_imm = 1'b1; e.mw = 1'b1; step(e, 1'b0);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
